// File: rtl/izero_isa_pkg.sv
// iZero ISA constants, instruction formats and field positions shared by the
// instruction encoder and the control-unit decoder.
package izero_isa_pkg;

   typedef enum logic [1:0] {
      FMT_R    = 2'd0,
      FMT_I    = 2'd1,
      FMT_J    = 2'd2,
      FMT_RSVD = 2'd3
   } fmt_e;

   localparam logic [5:0] OP_RTYPE    = 6'h00;
   localparam logic [5:0] OP_I_FIRST  = 6'h01;
   localparam logic [5:0] OP_I_LAST   = 6'h15;
   localparam logic [5:0] OP_J        = 6'h16;
   localparam logic [5:0] OP_JAL      = 6'h17;
   localparam logic [5:0] OP_JR       = 6'h18;
   localparam logic [5:0] OP_I2_FIRST = 6'h19;
   localparam logic [5:0] OP_I2_LAST  = 6'h1A;
   localparam logic [5:0] OP_I3_FIRST = 6'h1C;
   localparam logic [5:0] OP_I3_LAST  = 6'h20;
   localparam logic [5:0] FUNC_LAST   = 6'h12;

   localparam int OP_LSB = 26;
   localparam int RS_LSB = 21;
   localparam int RT_LSB = 16;
   localparam int RD_LSB = 11;

   // Opcode 0x1B and everything above 0x20 are holes in the I-type map.
   function automatic logic is_legal(fmt_e fmt, logic [5:0] op, logic [5:0] func);
      logic ok;
      ok = 1'b0;
      case (fmt)
         FMT_R:   ok = (op == OP_RTYPE) && (func <= FUNC_LAST);
         FMT_I:   ok = op inside {[OP_I_FIRST:OP_I_LAST], [OP_I2_FIRST:OP_I2_LAST],
                                  [OP_I3_FIRST:OP_I3_LAST]};
         FMT_J:   ok = op inside {OP_J, OP_JAL, OP_JR};
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [31:0] pack_word(fmt_e fmt, logic [5:0] op, logic [5:0] func,
                                             logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                             logic [15:0] imm, logic [25:0] target);
      logic [31:0] w;
      case (fmt)
         FMT_R:   w = (32'(OP_RTYPE) << OP_LSB) | (32'(rs) << RS_LSB) |
                      (32'(rt) << RT_LSB) | (32'(rd) << RD_LSB) | 32'(func);
         FMT_I:   w = (32'(op) << OP_LSB) | (32'(rs) << RS_LSB) |
                      (32'(rt) << RT_LSB) | 32'(imm);
         default: w = (32'(op) << OP_LSB) | 32'(target);
      endcase
      return w;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and simultaneous push/pop,
// which is accepted even when full because the pop frees the slot.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/instruction_encoder.sv
// Validates and packs field-level iZero instructions, buffers them and writes
// them into instruction memory from a programmable base address.
module instruction_encoder
   import izero_isa_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] word_count,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_fmt,
   input  logic [5:0]        in_op,
   input  logic [5:0]        in_func,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   input  logic              im_grant,
   output logic              im_write,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [7:0]        err_count
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;

   state_e            state;
   logic [ADDR_W-1:0] accepted;
   logic [ADDR_W-1:0] target_count;
   logic [ADDR_W-1:0] next_addr;
   logic [31:0]       packed_word;
   logic [31:0]       fifo_head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   logic              fire;
   logic              legal;

   assign in_ready    = (state == RUN) && !fifo_full && (accepted < target_count);
   assign fire        = in_valid && in_ready;
   assign legal       = is_legal(fmt_e'(in_fmt), in_op, in_func);
   assign packed_word = pack_word(fmt_e'(in_fmt), in_op, in_func, in_rs, in_rt, in_rd,
                                  in_imm, in_target);
   assign fifo_push   = fire && legal;
   assign fifo_pop    = !fifo_empty && im_grant;

   sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (packed_word),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Session FSM plus the registered IM write port; a pop this cycle becomes
   // the write presented next cycle, so DRAIN only needs to wait for empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         accepted     <= '0;
         target_count <= '0;
         next_addr    <= '0;
         im_write     <= 1'b0;
         im_addr      <= '0;
         im_data      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         err_count    <= '0;
      end else begin
         im_write <= fifo_pop;
         done     <= 1'b0;
         if (fifo_pop) begin
            im_addr   <= next_addr;
            im_data   <= fifo_head;
            next_addr <= next_addr + 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  next_addr    <= base_addr;
                  target_count <= word_count;
                  accepted     <= '0;
                  err          <= 1'b0;
                  err_count    <= '0;
                  if (word_count == '0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (fire) begin
                  if (legal) begin
                     accepted <= accepted + 1'b1;
                     if (accepted + ADDR_W'(1) == target_count) state <= DRAIN;
                  end else begin
                     err <= 1'b1;
                     if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                  end
               end
            end
            DRAIN: begin
               if (fifo_empty) begin
                  state <= FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            FIN: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: vector table, directed multi-cycle
// sequences and randomized sessions against a behavioural model.
module tb_instruction_encoder;

   localparam int ADDR_W = 10;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] word_count;
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_fmt;
   logic [5:0]        in_op;
   logic [5:0]        in_func;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [15:0]       in_imm;
   logic [25:0]       in_target;
   logic              im_grant;
   logic              im_write;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_data;
   logic              busy;
   logic              done;
   logic              err;
   logic [7:0]        err_count;

   instruction_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
      .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_op(in_op),
      .in_func(in_func), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
      .in_target(in_target), .im_grant(im_grant), .im_write(im_write), .im_addr(im_addr),
      .im_data(im_data), .busy(busy), .done(done), .err(err), .err_count(err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  fmt;
      logic [5:0]  op;
      logic [5:0]  func;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic [25:0] target;
   } instr_t;

   typedef struct {
      instr_t      ins;
      bit          exp_err;
      logic [31:0] exp_word;
   } vec_t;

   int              errors = 0;
   int              checks = 0;
   int              cyc = 0;
   instr_t          instr_q[$];
   logic [41:0]     wr_log[$];
   int              wr_cyc[$];
   int              done_cnt = 0;
   int              done_cyc = 0;
   int              start_cyc = 0;
   bit              ready_seen = 0;
   int              grant_block = 0;
   bit              grant_random = 0;
   int              fed = 0;
   int              fed_at_unblock = -1;
   logic            ready_at_unblock = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   // Write/done/ready observer, sampled on the falling edge.
   always @(negedge clk) begin
      if (im_write) begin
         wr_log.push_back({im_addr, im_data});
         wr_cyc.push_back(cyc);
      end
      if (done) begin
         if (done_cnt == 0) done_cyc = cyc;
         done_cnt++;
      end
      if (in_ready) ready_seen = 1'b1;
   end

   task automatic tick();
      @(negedge clk);
      #1;
      if (grant_block > 0) begin
         im_grant = 1'b0;
         grant_block--;
         if (grant_block == 0) begin
            fed_at_unblock   = fed;
            ready_at_unblock = in_ready;
         end
      end else begin
         im_grant = grant_random ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic instr_t mk(input logic [1:0] fmt, input logic [5:0] op,
                                 input logic [5:0] func, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [15:0] imm, input logic [25:0] target);
      instr_t i;
      i.fmt = fmt; i.op = op; i.func = func; i.rs = rs; i.rt = rt; i.rd = rd;
      i.imm = imm; i.target = target;
      return i;
   endfunction

   // Reference model: legality straight from the opcode/func map, packing as field arithmetic.
   function automatic bit modelLegal(input instr_t i);
      int op;
      op = int'(i.op);
      case (i.fmt)
         2'd0:    return (op == 0) && (int'(i.func) <= 18);
         2'd1:    return (op >= 1 && op <= 21) || op == 25 || op == 26 || (op >= 28 && op <= 32);
         2'd2:    return op == 22 || op == 23 || op == 24;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] modelPack(input instr_t i);
      logic [31:0] w;
      case (i.fmt)
         2'd0:    w = 32'(i.rs) * 32'h200000 + 32'(i.rt) * 32'h10000 + 32'(i.rd) * 32'h800
                      + 32'(i.func);
         2'd1:    w = 32'(i.op) * 32'h4000000 + 32'(i.rs) * 32'h200000
                      + 32'(i.rt) * 32'h10000 + 32'(i.imm);
         default: w = 32'(i.op) * 32'h4000000 + 32'(i.target);
      endcase
      return w;
   endfunction

   task automatic driveFields(input instr_t i);
      in_fmt = i.fmt; in_op = i.op; in_func = i.func; in_rs = i.rs; in_rt = i.rt;
      in_rd = i.rd; in_imm = i.imm; in_target = i.target;
   endtask

   task automatic applyStimulus(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] count);
      int budget;
      int n;
      wr_log.delete();
      wr_cyc.delete();
      done_cnt   = 0;
      ready_seen = 1'b0;
      fed        = 0;
      base_addr  = base;
      word_count = count;
      start      = 1'b1;
      start_cyc  = cyc;
      tick();
      start  = 1'b0;
      budget = 200 + 4 * instr_q.size();
      n      = 0;
      while (fed < instr_q.size() && done_cnt == 0 && n < budget) begin
         driveFields(instr_q[fed]);
         in_valid = 1'b1;
         if (in_ready) fed++;
         tick();
         n++;
      end
      in_valid = 1'b0;
      while (done_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      tick();
      tick();
   endtask

   task automatic checkSession(input string tag, input logic [ADDR_W-1:0] base,
                               input logic [ADDR_W-1:0] count);
      logic [ADDR_W-1:0] exp_addr[$];
      logic [31:0]       exp_data[$];
      int                n_illegal;
      int                n_legal;
      n_illegal = 0;
      n_legal   = 0;
      foreach (instr_q[k]) begin
         if (n_legal >= int'(count)) break;
         if (modelLegal(instr_q[k])) begin
            exp_addr.push_back(ADDR_W'(int'(base) + n_legal));
            exp_data.push_back(modelPack(instr_q[k]));
            n_legal++;
         end else begin
            n_illegal++;
         end
      end
      checkOutput({tag, "_nwrites"}, 64'(wr_log.size()), 64'(exp_data.size()));
      for (int k = 0; k < exp_data.size() && k < wr_log.size(); k++) begin
         checkOutput($sformatf("%s_addr%0d", tag, k), 64'(wr_log[k][41:32]), 64'(exp_addr[k]));
         checkOutput($sformatf("%s_data%0d", tag, k), 64'(wr_log[k][31:0]), 64'(exp_data[k]));
      end
      checkOutput({tag, "_err"}, 64'(err), 64'(n_illegal > 0));
      checkOutput({tag, "_err_count"}, 64'(err_count), 64'(n_illegal > 255 ? 255 : n_illegal));
      checkOutput({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
      checkOutput({tag, "_busy_after"}, 64'(busy), 64'd0);
   endtask

   vec_t   vecs[13];
   instr_t filler;
   instr_t ri;
   int     legal_n;
   int     cnt;
   logic [ADDR_W-1:0] rbase;

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; in_valid = 1'b0;
      in_fmt = '0; in_op = '0; in_func = '0; in_rs = '0; in_rt = '0; in_rd = '0;
      in_imm = '0; in_target = '0; im_grant = 1'b1;

      filler   = mk(2'd0, 6'h00, 6'h00, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      vecs[0]  = '{mk(2'd0, 6'h00, 6'h00, 5'd1,  5'd2, 5'd3,  16'hBEEF, 26'h2AAAAAA), 1'b0, 32'h00221800};
      vecs[1]  = '{mk(2'd1, 6'h01, 6'h3F, 5'd0,  5'd5, 5'd31, 16'h000A, 26'h3FFFFFF), 1'b0, 32'h0405000A};
      vecs[2]  = '{mk(2'd2, 6'h17, 6'h3F, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000100), 1'b0, 32'h5C000100};
      vecs[3]  = '{mk(2'd0, 6'h00, 6'h12, 5'd31, 5'd0, 5'd0,  16'h1234, 26'h1555555), 1'b0, 32'h03E00012};
      vecs[4]  = '{mk(2'd0, 6'h00, 6'h13, 5'd4,  5'd4, 5'd4,  16'h0, 26'h0), 1'b1, 32'h00221800};
      vecs[5]  = '{mk(2'd1, 6'h1B, 6'h00, 5'd4,  5'd4, 5'd4,  16'h0, 26'h0), 1'b1, 32'h00221800};
      vecs[6]  = '{mk(2'd1, 6'h20, 6'h2A, 5'd0,  5'd0, 5'd9,  16'hFFFF, 26'h0), 1'b0, 32'h8000FFFF};
      vecs[7]  = '{mk(2'd3, 6'h01, 6'h00, 5'd1,  5'd1, 5'd1,  16'h1, 26'h1), 1'b1, 32'h00221800};
      vecs[8]  = '{mk(2'd0, 6'h05, 6'h00, 5'd1,  5'd1, 5'd1,  16'h0, 26'h0), 1'b1, 32'h00221800};
      vecs[9]  = '{mk(2'd2, 6'h18, 6'h15, 5'd7,  5'd7, 5'd7,  16'h7777, 26'h3FFFFFF), 1'b0, 32'h63FFFFFF};
      vecs[10] = '{mk(2'd1, 6'h15, 6'h00, 5'd2,  5'd3, 5'd0,  16'h1234, 26'h0), 1'b0, 32'h54431234};
      vecs[11] = '{mk(2'd2, 6'h19, 6'h00, 5'd0,  5'd0, 5'd0,  16'h0, 26'h1), 1'b1, 32'h00221800};
      vecs[12] = '{mk(2'd1, 6'h16, 6'h00, 5'd0,  5'd0, 5'd0,  16'h5, 26'h0), 1'b1, 32'h00221800};

      repeat (3) tick();
      rst = 1'b0;
      tick();
      checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
      checkOutput("reset_im_write", 64'(im_write), 64'd0);
      checkOutput("reset_im_addr", 64'(im_addr), 64'd0);
      checkOutput("reset_im_data", 64'(im_data), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_err", 64'(err), 64'd0);
      checkOutput("reset_err_count", 64'(err_count), 64'd0);

      // One-word sessions: a legal vector is the word written, an illegal one
      // leaves the trailing filler add as the only write.
      for (int i = 0; i < 13; i++) begin
         instr_q.delete();
         instr_q.push_back(vecs[i].ins);
         instr_q.push_back(filler);
         applyStimulus(ADDR_W'(10'h100 + i), 10'd1);
         checkOutput($sformatf("vec%0d_nwrites", i), 64'(wr_log.size()), 64'd1);
         if (wr_log.size() > 0) begin
            checkOutput($sformatf("vec%0d_addr", i), 64'(wr_log[0][41:32]), 64'(10'h100 + i));
            checkOutput($sformatf("vec%0d_data", i), 64'(wr_log[0][31:0]), 64'(vecs[i].exp_word));
         end
         checkOutput($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
         checkOutput($sformatf("vec%0d_done", i), 64'(done_cnt), 64'd1);
      end

      // Single add: write lands before the done pulse.
      instr_q.delete();
      instr_q.push_back(filler);
      applyStimulus(10'h010, 10'd1);
      checkSession("t1", 10'h010, 10'd1);
      if (wr_log.size() == 1)
         checkOutput("t1_write_before_done", 64'(wr_cyc[0] < done_cyc), 64'd1);

      // Two words across the top of the address space.
      instr_q.delete();
      instr_q.push_back(vecs[1].ins);
      instr_q.push_back(vecs[2].ins);
      applyStimulus(10'h3FF, 10'd2);
      checkSession("t2", 10'h3FF, 10'd2);
      if (wr_log.size() == 2) begin
         checkOutput("t2_wrap_addr", 64'(wr_log[1][41:32]), 64'h000);
         checkOutput("t2_wrap_data", 64'(wr_log[1][31:0]), 64'h5C000100);
      end

      // Two illegal words ahead of the one legal word.
      instr_q.delete();
      instr_q.push_back(vecs[4].ins);
      instr_q.push_back(vecs[5].ins);
      instr_q.push_back(filler);
      applyStimulus(10'h020, 10'd1);
      checkSession("t3", 10'h020, 10'd1);
      checkOutput("t3_err_count_const", 64'(err_count), 64'd2);

      // Write side stalled: acceptance stops at FIFO depth, then drains back-to-back.
      instr_q.delete();
      for (int k = 0; k < 6; k++)
         instr_q.push_back(mk(2'd0, 6'h00, 6'(k), 5'(k), 5'(k + 1), 5'(k + 2), 16'h0, 26'h0));
      grant_block    = 10;
      fed_at_unblock = -1;
      applyStimulus(10'h200, 10'd6);
      checkSession("t4", 10'h200, 10'd6);
      checkOutput("t4_accepted_while_stalled", 64'(fed_at_unblock), 64'd4);
      checkOutput("t4_ready_low_when_full", 64'(ready_at_unblock), 64'd0);
      if (wr_cyc.size() == 6)
         checkOutput("t4_back_to_back", 64'(wr_cyc[5] - wr_cyc[0]), 64'd5);

      // Empty session.
      instr_q.delete();
      applyStimulus(10'h055, 10'd0);
      checkSession("t5", 10'h055, 10'd0);
      checkOutput("t5_ready_never", 64'(ready_seen), 64'd0);
      checkOutput("t5_done_latency", 64'((done_cyc - start_cyc) >= 1 && (done_cyc - start_cyc) <= 2), 64'd1);

      // Error counter saturation.
      instr_q.delete();
      for (int k = 0; k < 260; k++)
         instr_q.push_back(mk(2'd3, 6'(k), 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0));
      instr_q.push_back(filler);
      applyStimulus(10'h300, 10'd1);
      checkSession("sat", 10'h300, 10'd1);

      // Randomized sessions with a random grant pattern.
      grant_random = 1'b1;
      for (int s = 0; s < 15; s++) begin
         instr_q.delete();
         cnt     = $urandom_range(1, 8);
         rbase   = ADDR_W'($urandom);
         legal_n = 0;
         while (legal_n < cnt) begin
            ri = mk(2'($urandom), 6'($urandom_range(0, 35)), 6'($urandom_range(0, 22)),
                    5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
            if (ri.fmt == 2'd0 && $urandom_range(0, 7) != 0) ri.op = 6'h00;
            if (ri.fmt == 2'd2) ri.op = 6'($urandom_range(20, 27));
            if (modelLegal(ri)) legal_n++;
            instr_q.push_back(ri);
         end
         instr_q.push_back(filler);
         applyStimulus(rbase, ADDR_W'(cnt));
         checkSession($sformatf("rnd%0d", s), rbase, ADDR_W'(cnt));
      end
      grant_random = 1'b0;

      // Reset with three words buffered behind a stalled write port.
      instr_q.delete();
      for (int k = 0; k < 6; k++)
         instr_q.push_back(mk(2'd1, 6'h01, 6'h00, 5'd0, 5'(k), 5'd0, 16'(k), 26'h0));
      wr_log.delete();
      done_cnt    = 0;
      grant_block = 40;
      fed         = 0;
      base_addr   = 10'h050;
      word_count  = 10'd6;
      start       = 1'b1;
      tick();
      start = 1'b0;
      for (int n = 0; n < 20 && fed < 3; n++) begin
         driveFields(instr_q[fed]);
         in_valid = 1'b1;
         if (in_ready) fed++;
         tick();
      end
      in_valid = 1'b0;
      checkOutput("t6_buffered", 64'(fed), 64'd3);
      tick();
      rst = 1'b1;
      tick();
      checkOutput("t6_im_write", 64'(im_write), 64'd0);
      checkOutput("t6_busy", 64'(busy), 64'd0);
      checkOutput("t6_in_ready", 64'(in_ready), 64'd0);
      rst         = 1'b0;
      grant_block = 0;
      wr_log.delete();
      repeat (12) tick();
      checkOutput("t6_no_writes_after", 64'(wr_log.size()), 64'd0);
      checkOutput("t6_no_done", 64'(done_cnt), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
